cpu_datapath: RTL and testbench



---
 rtl/cpu_datapath.sv | 199 +++++++++++++++++++
 tb/tb_cpu_datapath.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
//
// Purpose:
//   Single-bus 32-bit CPU datapath. It holds a register-file slice (R2-R7) and
//   the PC, IR, MAR, MDR, Y, Z (64-bit, loaded as two halves), HI and LO
//   registers, plus a combinational ALU. All of them share one 32-bit bus.
//   Every transfer is driven by external strobes from a control unit. When no
//   out strobe is asserted, the bus shows the last value that was driven onto
//   it.
//
// Ports:
//   clock, clear        rising-edge clock; asynchronous active-high reset
//   Mdatain[31:0]       memory read data
//   MDRread             MDR input select (1: Mdatain, 0: bus)
//   *out strobes        bus-drive requests; fixed priority resolves conflicts
//   *in strobes         register load enables; registers load from the bus
//                       (Z halves load from the ALU)
//   IncPC               forces the ALU result to bus + 1
//   bus_q, *_q          observation of the bus and register contents
// -----------------------------------------------------------------------------
module cpu_datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] Mdatain,
    input  logic        MDRread,
    // bus-drive strobes
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        IRout,
    input  logic        MARout,
    input  logic        RYout,
    input  logic        RZoutLo,
    input  logic        RZoutHi,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    // load enables
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        RYin,
    input  logic        RZinLo,
    input  logic        RZinHi,
    input  logic        LOin,
    input  logic        HIin,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        IncPC,
    // observation
    output logic [31:0] bus_q,
    output logic [31:0] pc_q,
    output logic [31:0] ir_q,
    output logic [31:0] mar_q,
    output logic [31:0] mdr_q,
    output logic [31:0] y_q,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic [31:0] zhi_q,
    output logic [31:0] zlo_q
);

    typedef enum logic [4:0] {
        OP_ADD = 5'd3,
        OP_SUB = 5'd4,
        OP_AND = 5'd5,
        OP_OR  = 5'd6,
        OP_MUL = 5'd16,
        OP_NEG = 5'd17,
        OP_NOT = 5'd18
    } alu_op_e;

    logic [31:0] r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo, r_zhi, r_zlo;
    logic [31:0] r_bus_hold;
    logic [31:0] r_gp [2:7];

    logic [7:2]  w_gp_out;
    logic [7:2]  w_gp_in;
    logic        w_any_out;
    logic [31:0] w_bus;
    logic [63:0] w_alu;
    logic signed [63:0] w_a_ext, w_b_ext, w_prod;
    alu_op_e     w_op;

    assign w_gp_out  = {R7out, R6out, R5out, R4out, R3out, R2out};
    assign w_gp_in   = {R7in, R6in, R5in, R4in, R3in, R2in};
    assign w_any_out = MDRout | PCout | RZoutLo | RZoutHi | IRout | RYout |
                       MARout | (|w_gp_out);

    // Bus driver: the highest-priority out strobe wins. With no driver, the
    // bus keeps showing the last driven value, so the ALU still sees the
    // operand in the cycle after it was driven (for example, the Z load of
    // a multiply).
    always_comb begin
        // NOTE: the default assignment first keeps this combinational; a path
        // that leaves w_bus unassigned would infer a latch.
        w_bus = r_bus_hold;
        if      (MDRout)      w_bus = r_mdr;
        else if (PCout)       w_bus = r_pc;
        else if (RZoutLo)     w_bus = r_zlo;
        else if (RZoutHi)     w_bus = r_zhi;
        else if (IRout)       w_bus = r_ir;
        else if (RYout)       w_bus = r_y;
        else if (MARout)      w_bus = r_mar;
        else if (w_gp_out[2]) w_bus = r_gp[2];
        else if (w_gp_out[3]) w_bus = r_gp[3];
        else if (w_gp_out[4]) w_bus = r_gp[4];
        else if (w_gp_out[5]) w_bus = r_gp[5];
        else if (w_gp_out[6]) w_bus = r_gp[6];
        else if (w_gp_out[7]) w_bus = r_gp[7];
    end

    // ALU: A = Y, B = bus. Signed multiply uses explicitly sign-extended
    // 64-bit operands, so the product width is unambiguous.
    assign w_op    = alu_op_e'(r_ir[31:27]);
    assign w_a_ext = {{32{r_y[31]}}, r_y};
    assign w_b_ext = {{32{w_bus[31]}}, w_bus};
    assign w_prod  = w_a_ext * w_b_ext;

    always_comb begin
        w_alu = {32'd0, w_bus};
        if (IncPC) begin
            w_alu = {32'd0, w_bus + 32'd1};
        end else begin
            case (w_op)
                OP_ADD:  w_alu = {32'd0, r_y + w_bus};
                OP_SUB:  w_alu = {32'd0, r_y - w_bus};
                OP_AND:  w_alu = {32'd0, r_y & w_bus};
                OP_OR:   w_alu = {32'd0, r_y | w_bus};
                OP_MUL:  w_alu = w_prod;
                OP_NEG:  w_alu = {32'd0, -w_bus};
                OP_NOT:  w_alu = {32'd0, ~w_bus};
                default: w_alu = {32'd0, w_bus};
            endcase
        end
    end

    // Special-purpose registers. All of them load on the same edge from the
    // pre-edge bus, so a register may drive and load in one cycle.
    always_ff @(posedge clock or posedge clear) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge bus regardless of statement order.
        if (clear) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_mar      <= '0;
            r_mdr      <= '0;
            r_y        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_zhi      <= '0;
            r_zlo      <= '0;
            r_bus_hold <= '0;
        end else begin
            if (PCin)   r_pc  <= w_bus;
            if (IRin)   r_ir  <= w_bus;
            if (MARin)  r_mar <= w_bus;
            if (MDRin)  r_mdr <= MDRread ? Mdatain : w_bus;
            if (RYin)   r_y   <= w_bus;
            if (HIin)   r_hi  <= w_bus;
            if (LOin)   r_lo  <= w_bus;
            if (RZinHi) r_zhi <= w_alu[63:32];
            if (RZinLo) r_zlo <= w_alu[31:0];
            if (w_any_out) r_bus_hold <= w_bus;
        end
    end

    // General-purpose slice R2-R7.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            // NOTE: the register file is small, so it is cleared explicitly
            // rather than being treated as RAM that powers up undefined.
            for (int i = 2; i <= 7; i++) r_gp[i] <= '0;
        end else begin
            for (int i = 2; i <= 7; i++)
                if (w_gp_in[i]) r_gp[i] <= w_bus;
        end
    end

    assign bus_q = w_bus;
    assign pc_q  = r_pc;
    assign ir_q  = r_ir;
    assign mar_q = r_mar;
    assign mdr_q = r_mdr;
    assign y_q   = r_y;
    assign hi_q  = r_hi;
    assign lo_q  = r_lo;
    assign zhi_q = r_zhi;
    assign zlo_q = r_zlo;

endmodule

// File: tb/tb_cpu_datapath.sv
// -----------------------------------------------------------------------------
// tb_cpu_datapath
//
// Purpose:
//   Directed, self-checking bench for cpu_datapath. Inputs change 1 ns after
//   a rising edge. Outputs are sampled 1 ns after the strobes change, or
//   1 ns after the edge that loads a register.
// -----------------------------------------------------------------------------
module tb_cpu_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        MDRread;
    logic PCout, MDRout, IRout, MARout, RYout, RZoutLo, RZoutHi;
    logic R2out, R3out, R4out, R5out, R6out, R7out;
    logic PCin, MDRin, IRin, MARin, RYin, RZinLo, RZinHi, LOin, HIin;
    logic R2in, R3in, R4in, R5in, R6in, R7in;
    logic IncPC;
    logic [31:0] bus_q, pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, zhi_q, zlo_q;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cpu_datapath dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .MDRread(MDRread),
        .PCout(PCout), .MDRout(MDRout), .IRout(IRout), .MARout(MARout),
        .RYout(RYout), .RZoutLo(RZoutLo), .RZoutHi(RZoutHi),
        .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out),
        .R6out(R6out), .R7out(R7out),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .MARin(MARin), .RYin(RYin),
        .RZinLo(RZinLo), .RZinHi(RZinHi), .LOin(LOin), .HIin(HIin),
        .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in), .R6in(R6in),
        .R7in(R7in), .IncPC(IncPC),
        .bus_q(bus_q), .pc_q(pc_q), .ir_q(ir_q), .mar_q(mar_q), .mdr_q(mdr_q),
        .y_q(y_q), .hi_q(hi_q), .lo_q(lo_q), .zhi_q(zhi_q), .zlo_q(zlo_q)
    );

    task automatic clr_strobes();
        MDRread = 0; IncPC = 0;
        PCout = 0; MDRout = 0; IRout = 0; MARout = 0; RYout = 0;
        RZoutLo = 0; RZoutHi = 0;
        R2out = 0; R3out = 0; R4out = 0; R5out = 0; R6out = 0; R7out = 0;
        PCin = 0; MDRin = 0; IRin = 0; MARin = 0; RYin = 0;
        RZinLo = 0; RZinHi = 0; LOin = 0; HIin = 0;
        R2in = 0; R3in = 0; R4in = 0; R5in = 0; R6in = 0; R7in = 0;
    endtask

    // One clock: strobes set by the caller are held across the edge and
    // cleared 1 ns afterwards.
    task automatic step();
        @(posedge clock);
        #1;
        clr_strobes();
    endtask

    task automatic mem_to_mdr(input logic [31:0] val);
        Mdatain = val; MDRread = 1; MDRin = 1;
        step();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (pc_q !== 32'd0)  begin errors++; $display("FAIL reset_pc got %h want 0", pc_q); end
        checks++; if (bus_q !== 32'd0) begin errors++; $display("FAIL reset_bus got %h want 0", bus_q); end
        checks++; if ({zhi_q, zlo_q, hi_q, lo_q} !== 128'd0) begin errors++; $display("FAIL reset_z_hi_lo got %h want 0", {zhi_q, zlo_q, hi_q, lo_q}); end
        @(posedge clock); #1;
        clear = 0;
    endtask

    task automatic test_mem_load();
        mem_to_mdr(32'h0007_8945);
        checks++; if (mdr_q !== 32'h0007_8945) begin errors++; $display("FAIL mdr_from_mem got %h want 00078945", mdr_q); end
        MDRout = 1; R2in = 1; step();
        mem_to_mdr(32'h0005_4987);
        MDRout = 1; R6in = 1; step();
        R2out = 1; #1;
        checks++; if (bus_q !== 32'h0007_8945) begin errors++; $display("FAIL r2_load got %h want 00078945", bus_q); end
        clr_strobes(); R6out = 1; #1;
        checks++; if (bus_q !== 32'h0005_4987) begin errors++; $display("FAIL r6_load got %h want 00054987", bus_q); end
        clr_strobes();
    endtask

    task automatic test_fetch_inc();
        PCout = 1; MARin = 1; IncPC = 1; RZinLo = 1; step();
        checks++; if (mar_q !== 32'd0) begin errors++; $display("FAIL fetch_mar got %h want 0", mar_q); end
        checks++; if (zlo_q !== 32'd1) begin errors++; $display("FAIL fetch_zlo got %h want 1", zlo_q); end
        checks++; if (pc_q !== 32'd0)  begin errors++; $display("FAIL fetch_pc got %h want 0", pc_q); end
    endtask

    task automatic load_ir(input logic [31:0] val);
        mem_to_mdr(val);
        MDRout = 1; IRin = 1; step();
    endtask

    // Ra = R2, Rb = R6; the Z load happens with no bus driver, so the ALU
    // sees Rb through the hold register.
    task automatic run_mul(input string name, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        R2out = 1; RYin = 1; step();
        R6out = 1; step();
        RZinLo = 1; RZinHi = 1; step();
        RZoutLo = 1; LOin = 1; step();
        RZoutHi = 1; HIin = 1; step();
        checks++; if (lo_q !== exp_lo) begin errors++; $display("FAIL %s_lo got %h want %h", name, lo_q, exp_lo); end
        checks++; if (hi_q !== exp_hi) begin errors++; $display("FAIL %s_hi got %h want %h", name, hi_q, exp_hi); end
    endtask

    task automatic test_mul();
        load_ir(32'h822B_8000);
        checks++; if (ir_q !== 32'h822B_8000) begin errors++; $display("FAIL ir_load got %h want 822b8000", ir_q); end
        // 0x00078945 * 0x00054987 = 493893 * 346503 = 171135406179
        //                         = 0x00000027_D8771063
        run_mul("mul_pos", 32'h0000_0027, 32'hD877_1063);
        // -1 * 2 = -2 as a 64-bit signed product
        mem_to_mdr(32'hFFFF_FFFF); MDRout = 1; R2in = 1; step();
        mem_to_mdr(32'h0000_0002); MDRout = 1; R6in = 1; step();
        run_mul("mul_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    endtask

    // Y = a, bus = b driven from MDR, then both Z halves load.
    task automatic alu_case(input string name, input logic [31:0] ir,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic inc, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        load_ir(ir);
        mem_to_mdr(a); MDRout = 1; RYin = 1; step();
        mem_to_mdr(b);
        MDRout = 1; RZinLo = 1; RZinHi = 1; IncPC = inc; step();
        checks++; if ({zhi_q, zlo_q} !== {exp_hi, exp_lo}) begin
            errors++; $display("FAIL %s got %h_%h want %h_%h", name, zhi_q, zlo_q, exp_hi, exp_lo);
        end
    endtask

    task automatic test_alu_ops();
        alu_case("add_wrap", 32'h1800_0000, 32'hFFFF_FFFF, 32'h0000_0002, 0, 32'h0, 32'h0000_0001);
        alu_case("sub_borrow", 32'h2000_0000, 32'h0000_0005, 32'h0000_0007, 0, 32'h0, 32'hFFFF_FFFE);
        alu_case("and", 32'h2800_0000, 32'hF0F0_FFFF, 32'h0FF0_F0F0, 0, 32'h0, 32'h00F0_F0F0);
        alu_case("or", 32'h3000_0000, 32'hF0F0_FFFF, 32'h0FF0_F0F0, 0, 32'h0, 32'hFFF0_FFFF);
        alu_case("neg", 32'h8800_0000, 32'h1234_5678, 32'h0000_0005, 0, 32'h0, 32'hFFFF_FFFB);
        alu_case("not", 32'h9000_0000, 32'h1234_5678, 32'h0000_FFFF, 0, 32'h0, 32'hFFFF_0000);
        alu_case("pass_default", 32'h0000_0000, 32'h1234_5678, 32'h0000_1234, 0, 32'h0, 32'h0000_1234);
        // IncPC overrides a mul opcode; the all-ones bus wraps to zero.
        alu_case("incpc_override", 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFF, 1, 32'h0, 32'h0000_0000);
    endtask

    task automatic test_priority_hold();
        mem_to_mdr(32'h1234_5678); MDRout = 1; PCin = 1; step();
        mem_to_mdr(32'hA5A5_A5A5); MDRout = 1; R3in = 1; step();
        checks++; if (pc_q !== 32'h1234_5678) begin errors++; $display("FAIL pc_load got %h want 12345678", pc_q); end
        PCout = 1; R3out = 1; #1;
        checks++; if (bus_q !== 32'h1234_5678) begin errors++; $display("FAIL prio_pc_r3 got %h want 12345678", bus_q); end
        MDRout = 1; #1;
        checks++; if (bus_q !== 32'hA5A5_A5A5) begin errors++; $display("FAIL prio_mdr_pc got %h want a5a5a5a5", bus_q); end
        MDRout = 0; step();
        #1;
        checks++; if (bus_q !== 32'h1234_5678) begin errors++; $display("FAIL bus_hold got %h want 12345678", bus_q); end
    endtask

    task automatic test_async_clear();
        #2;
        clear = 1;
        #1;
        checks++; if (pc_q !== 32'd0)  begin errors++; $display("FAIL clear_pc got %h want 0", pc_q); end
        checks++; if (bus_q !== 32'd0) begin errors++; $display("FAIL clear_bus got %h want 0", bus_q); end
        checks++; if ({ir_q, mdr_q, y_q, hi_q, lo_q, zlo_q} !== 192'd0) begin
            errors++; $display("FAIL clear_regs got %h want 0", {ir_q, mdr_q, y_q, hi_q, lo_q, zlo_q});
        end
        // Loads are ignored while clear is held across an edge.
        mem_to_mdr(32'hDEAD_BEEF);
        checks++; if (mdr_q !== 32'd0) begin errors++; $display("FAIL clear_blocks_load got %h want 0", mdr_q); end
        clear = 0;
    endtask

    initial begin
        clear = 1;
        Mdatain = '0;
        clr_strobes();
        test_reset();
        test_mem_load();
        test_fetch_inc();
        test_mul();
        test_alu_ops();
        test_priority_hold();
        test_async_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
